// File: rtl/spec_stage_pkg.sv
// Shared types for the registered stage that sits downstream of the spec inverter.
package spec_stage_pkg;

  localparam int WORD_W = 128;

  typedef logic [127:0] word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage : spec_stage_pkg

// File: rtl/spec_skid_stage.sv
// Two-entry skid buffer behind the spec inverter. It presents the words in order,
// together with their even parity and a wrapping count of output handshakes.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | nothing buffered; in_ready=1, out_valid=0
// ONE   | main holds the oldest word; in_ready=1, out_valid=1
// TWO   | main and skid both full; in_ready=0, out_valid=1
module spec_skid_stage
  import spec_stage_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] xfer_count
);

  skid_state_t      state_q, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_ready_q;
  logic [CNT_W-1:0] xfer_q;
  logic             push, pop;

  // Handshakes. in_ready comes from a flop, so push never depends on out_ready.
  always_comb begin
    push = in_valid && in_ready_q;
    pop  = (state_q != EMPTY) && out_ready;
  end

  // Next-state and next-data decode.
  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_nxt = in_data;
        end else if (push) begin
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can move the buffer.
        if (pop) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State, storage and ready flop. Reset discards the buffered words immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  // Output handshake counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q <= '0;
    end else if (pop) begin
      xfer_q <= xfer_q + CNT_W'(1);
    end
  end

  // Outputs come straight from the registers; parity is the XOR of main.
  always_comb begin
    in_ready   = in_ready_q;
    out_valid  = (state_q != EMPTY);
    out_data   = main_q;
    out_parity = ^main_q;
    xfer_count = xfer_q;
  end

endmodule : spec_skid_stage

// File: tb/tb_spec_skid_stage.sv
// Scoreboard bench for spec_skid_stage. The upstream inverter is modelled by driving ~word.
// A second instance with a 4-bit counter covers the wrap behaviour.
module tb_spec_skid_stage;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid, out_parity;
  logic [W-1:0] out_data;
  logic [15:0]  xfer_count;

  logic         in_ready4, out_valid4, out_parity4;
  logic [W-1:0] out_data4;
  logic [3:0]   xfer4;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  int           m_cnt = 0;
  logic [15:0]  m_xfer = '0;

  spec_skid_stage #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .xfer_count(xfer_count)
  );

  spec_skid_stage #(.WIDTH(W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_parity(out_parity4), .xfer_count(xfer4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (m_cnt != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_done", W'(m_cnt), W'(0));
  endtask

  // Scoreboard monitor: compares the DUT against the queue model on every falling edge.
  always @(negedge clk) begin
    logic [W-1:0] exp;
    logic         pop, push;
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      m_xfer = '0;
    end else begin
      chk("in_ready",   W'(in_ready),   W'(m_cnt != 2));
      chk("out_valid",  W'(out_valid),  W'(m_cnt != 0));
      chk("xfer_count", W'(xfer_count), W'(m_xfer));
      chk("in_ready4",  W'(in_ready4),  W'(m_cnt != 2));
      chk("out_valid4", W'(out_valid4), W'(m_cnt != 0));
      chk("xfer4",      W'(xfer4),      W'(m_xfer[3:0]));
      if (m_cnt != 0) begin
        exp = q[0];
        chk("out_data",    out_data,         exp);
        chk("out_parity",  W'(out_parity),   W'(^exp));
        chk("out_data4",   out_data4,        exp);
        chk("out_parity4", W'(out_parity4),  W'(^exp));
      end
      pop  = (m_cnt != 0) && out_ready;
      push = in_valid && (m_cnt != 2);
      if (pop) begin
        void'(q.pop_front());
        m_xfer = m_xfer + 16'd1;
      end
      if (push) q.push_back(in_data);
      m_cnt = q.size();
    end
  end

  initial begin
    logic [W-1:0] w;

    // Reset then idle for 10 cycles.
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_in_ready",  W'(in_ready),   W'(1));
      chk("idle_out_valid", W'(out_valid),  W'(0));
      chk("idle_out_data",  out_data,       W'(0));
      chk("idle_parity",    W'(out_parity), W'(0));
      chk("idle_xfer",      W'(xfer_count), W'(0));
    end

    // Single pass: upstream input 0, so the word is all ones.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = ~W'(0);
    cyc();
    in_valid = 1'b0;
    chk("single_valid",  W'(out_valid),  W'(1));
    chk("single_data",   out_data,       {W{1'b1}});
    chk("single_parity", W'(out_parity), W'(0));
    cyc();
    chk("single_xfer",   W'(xfer_count), W'(1));
    chk("single_empty",  W'(out_valid),  W'(0));

    // Back-pressure fill with a third word refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = ~W'(1);
    cyc();
    chk("bp_ready_after1", W'(in_ready), W'(1));
    in_data = ~W'(2);
    cyc();
    chk("bp_ready_after2", W'(in_ready), W'(0));
    in_data = ~W'(3);
    cyc();
    cyc();
    chk("bp_hold_data",   out_data,      ~W'(1));
    chk("bp_hold_ready",  W'(in_ready),  W'(0));
    chk("bp_hold_parity", W'(out_parity), W'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_second_data",   out_data,       ~W'(2));
    chk("bp_second_parity", W'(out_parity), W'(1));
    chk("bp_ready_back",    W'(in_ready),   W'(1));
    cyc();
    chk("bp_empty", W'(out_valid),  W'(0));
    chk("bp_xfer",  W'(xfer_count), W'(3));

    // Streaming: 1000 random words with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      in_data  = ~w;
      cyc();
      if (i > 0) chk("stream_ready", W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_xfer",  W'(xfer_count), W'(1000));
    chk("stream_empty", W'(out_valid),  W'(0));

    // Counter wrap on the 4-bit instance: pops start one edge after the first push.
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      in_valid = (k <= 17);
      in_data  = ~W'(k);
      cyc();
      if (k - 1 == 15) chk("wrap_pop15", W'(xfer4), W'(15));
      if (k - 1 == 16) chk("wrap_pop16", W'(xfer4), W'(0));
      if (k - 1 == 17) chk("wrap_pop17", W'(xfer4), W'(1));
    end
    in_valid = 1'b0;
    drain(10);

    // Reset mid-operation from TWO, asserted between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = ~W'(32'hA5A5_0001);
    cyc();
    in_data = ~W'(32'hA5A5_0002);
    cyc();
    in_valid = 1'b0;
    chk("mid_full_ready", W'(in_ready),  W'(0));
    chk("mid_full_valid", W'(out_valid), W'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", W'(out_valid),  W'(0));
    chk("mid_rst_ready", W'(in_ready),   W'(1));
    chk("mid_rst_xfer",  W'(xfer_count), W'(0));
    chk("mid_rst_xfer4", W'(xfer4),      W'(0));
    chk("mid_rst_data",  out_data,       W'(0));
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_no_emit", W'(out_valid), W'(0));
    end
    chk("mid_xfer_after", W'(xfer_count), W'(0));

    chk("queue_empty", W'(q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_spec_skid_stage
